// File: rtl/clk_gate_ctrl.sv
// Per-channel clock gating controller: OFF/ON/DRAIN/SLEEP FSM per channel driving a latch-based ICG.
// Default channel map: 0-5 UART0-5, 6-11 I2C0-5, 12 TIMER, 13 CALIB, 14 WDT, 15 ADC, 16 PWM.

module clk_gate_ctrl_icg (
    input  logic clk_i,
    input  logic en_i,
    output logic gclk_o
);

    logic en_lat;

    // Enable is captured while the clock is low, so gclk_o can never be truncated or glitched.
    always_latch begin
        if (!clk_i) en_lat <= en_i;
    end

    assign gclk_o = clk_i & en_lat;

endmodule

module clk_gate_ctrl #(
    parameter int unsigned NUM_CH = 17,
    parameter int unsigned IDLE_W = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rstn,
    input  logic [NUM_CH-1:0] gate_en_cfg,
    input  logic [NUM_CH-1:0] auto_gate_cfg,
    input  logic [IDLE_W-1:0] idle_thresh,
    input  logic [NUM_CH-1:0] periph_busy,
    input  logic [NUM_CH-1:0] periph_wake,
    output logic [NUM_CH-1:0] gclk,
    output logic [NUM_CH-1:0] clk_on,
    output logic [NUM_CH-1:0] sleep_evt
);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_ON,
        ST_DRAIN,
        ST_SLEEP
    } state_e;

    localparam logic [IDLE_W-1:0] CNT_ONE = IDLE_W'(1);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_e            state_q, state_d;
        logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
        logic              clk_on_q, sleep_evt_q;
        logic              idle_hit;

        always_comb begin
            idle_hit = gate_en_cfg[g] && auto_gate_cfg[g] && !periph_busy[g]
                       && (idle_cnt_q == idle_thresh);
            state_d  = state_q;
            case (state_q)
                ST_OFF: begin
                    if (gate_en_cfg[g]) state_d = ST_ON;
                end
                ST_ON: begin
                    if (!gate_en_cfg[g])  state_d = periph_busy[g] ? ST_DRAIN : ST_OFF;
                    else if (idle_hit)    state_d = ST_SLEEP;
                end
                ST_DRAIN: begin
                    if (gate_en_cfg[g])      state_d = ST_ON;
                    else if (!periph_busy[g]) state_d = ST_OFF;
                end
                ST_SLEEP: begin
                    if (!gate_en_cfg[g]) state_d = ST_OFF;
                    else if (periph_wake[g] || periph_busy[g] || !auto_gate_cfg[g])
                        state_d = ST_ON;
                end
                default: state_d = ST_OFF;
            endcase

            if ((state_q != ST_ON) || periph_busy[g] || !auto_gate_cfg[g])
                idle_cnt_d = '0;
            else if (idle_cnt_q != '1)
                idle_cnt_d = idle_cnt_q + CNT_ONE;
            else
                idle_cnt_d = idle_cnt_q;
        end

        always_ff @(posedge sys_clk or negedge sys_rstn) begin
            if (!sys_rstn) begin
                state_q     <= ST_OFF;
                idle_cnt_q  <= '0;
                clk_on_q    <= 1'b0;
                sleep_evt_q <= 1'b0;
            end else begin
                state_q     <= state_d;
                idle_cnt_q  <= idle_cnt_d;
                clk_on_q    <= (state_d == ST_ON) || (state_d == ST_DRAIN);
                sleep_evt_q <= (state_q == ST_ON) && (state_d == ST_SLEEP);
            end
        end

        assign clk_on[g]    = clk_on_q;
        assign sleep_evt[g] = sleep_evt_q;

        clk_gate_ctrl_icg u_icg (
            .clk_i  (sys_clk),
            .en_i   (clk_on_q),
            .gclk_o (gclk[g])
        );
    end

endmodule
